mem_access_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register. Turns the registered EX/MEM bundle (address in ALUOut, store data in DRAMIn, access type, sign control) into single-outstanding transactions on a wait-stated data-RAM bus. It aligns store data and generates byte enables, extracts and sign/zero-extends load data, and stalls the upstream pipeline until the bus acknowledges. Its registered outputs form the MEM/WB bundle feeding write-back.

---
 rtl/mem_access_unit_pkg.sv | 44 ++++
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_load_ext.sv | 26 ++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared widths, access/write-back encodings, FSM states and store-lane helpers for the MEM stage.
// Pure definitions, so there is no latency and no backpressure.
package mem_access_unit_pkg;

    localparam int WIDTH_PC      = 32;
    localparam int WIDTH_DATA    = 32;
    localparam int WIDTH_REGMARK = 5;

    localparam logic [1:0] DRAM_BYTE  = 2'b00;
    localparam logic [1:0] DRAM_HALF  = 2'b01;
    localparam logic [1:0] DRAM_WORD  = 2'b10;
    localparam logic [1:0] RWSEL_DRAM = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Encoding 2'b11 is handled as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size == DRAM_BYTE)      return 1'b0;
        else if (size == DRAM_HALF) return off[0];
        else                        return off != 2'b00;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DRAM_BYTE: return 4'b0001 << off;
            DRAM_HALF: return off[1] ? 4'b1100 : 4'b0011;
            DRAM_WORD: return 4'b1111;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] din);
        case (size)
            DRAM_BYTE: return {4{din[7:0]}};
            DRAM_HALF: return {2{din[15:0]}};
            default:   return din;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-RAM bus between the MEM stage (master) and the wait-stated RAM (slave).
// Request is held until a one-cycle ack; read data is valid in the ack cycle.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic                  bus_req;
    logic                  bus_we;
    logic [WIDTH_DATA-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [WIDTH_DATA-1:0] bus_wdata;
    logic                  bus_ack;
    logic [WIDTH_DATA-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_load_ext.sv
// Load lane select plus sign/zero extension; purely combinational (zero latency).
// No handshake, so no backpressure; reusable by write-back forwarding.
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            DRAM_BYTE: data = {{24{byte_v[7] & ~uns}}, byte_v};
            DRAM_HALF: data = {{16{half_v[15] & ~uns}}, half_v};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: EX/MEM bundle -> single-outstanding data-RAM transaction -> registered MEM/WB bundle.
// Non-access: 1 cycle, no stall; access: >=3 cycles with stall held until ack; misaligned accesses are dropped and flagged.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WIDTH_PC      = 32,
    parameter int WIDTH_DATA    = 32,
    parameter int WIDTH_REGMARK = 5
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH_PC-1:0]      pc,
    input  logic [1:0]               DRAM_EX_TYPE,
    input  logic                     DRAMWE,
    input  logic [1:0]               RWSel,
    input  logic [WIDTH_REGMARK-1:0] RegWr,
    input  logic                     RegWe,
    input  logic [WIDTH_DATA-1:0]    ALUOut,
    input  logic [WIDTH_DATA-1:0]    DRAMIn,
    input  logic                     Unsigned,
    mem_access_unit_if.master        bus,
    output logic                     stall,
    output logic [WIDTH_PC-1:0]      pc_o,
    output logic [WIDTH_REGMARK-1:0] RegWr_o,
    output logic                     RegWe_o,
    output logic [WIDTH_DATA-1:0]    WBData_o,
    output logic                     misalign_o
);

    state_t                   state;
    logic                     access;
    logic                     misaligned;
    logic [1:0]               lat_off;
    logic [1:0]               lat_size;
    logic                     lat_uns;
    logic [1:0]               lat_rwsel;
    logic [WIDTH_REGMARK-1:0] lat_regwr;
    logic                     lat_regwe;
    logic [WIDTH_PC-1:0]      lat_pc;
    logic [WIDTH_DATA-1:0]    lat_alu;
    logic [WIDTH_DATA-1:0]    load_data;
    logic [WIDTH_DATA-1:0]    ext_data;

    assign access     = DRAMWE || (RWSel == RWSEL_DRAM);
    assign misaligned = is_misaligned(DRAM_EX_TYPE, ALUOut[1:0]);

    // Gated by rst_n so the upstream pipeline is released the instant reset asserts.
    assign stall = rst_n &&
                   (((state == ST_IDLE) && access && !misaligned) || (state == ST_BUSY));

    mem_load_ext u_load_ext (
        .rdata (bus.bus_rdata),
        .off   (lat_off),
        .size  (lat_size),
        .uns   (lat_uns),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            lat_off       <= '0;
            lat_size      <= '0;
            lat_uns       <= 1'b0;
            lat_rwsel     <= '0;
            lat_regwr     <= '0;
            lat_regwe     <= 1'b0;
            lat_pc        <= '0;
            lat_alu       <= '0;
            load_data     <= '0;
            pc_o          <= '0;
            RegWr_o       <= '0;
            RegWe_o       <= 1'b0;
            WBData_o      <= '0;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!access) begin
                        pc_o     <= pc;
                        RegWr_o  <= RegWr;
                        RegWe_o  <= RegWe;
                        WBData_o <= ALUOut;
                    end else if (misaligned) begin
                        misalign_o <= 1'b1;
                        RegWe_o    <= 1'b0;
                        pc_o       <= pc;
                        RegWr_o    <= RegWr;
                        WBData_o   <= ALUOut;
                    end else begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= DRAMWE;
                        bus.bus_addr  <= {ALUOut[WIDTH_DATA-1:2], 2'b00};
                        bus.bus_be    <= store_be(DRAM_EX_TYPE, ALUOut[1:0]);
                        bus.bus_wdata <= store_lanes(DRAM_EX_TYPE, DRAMIn);
                        lat_off       <= ALUOut[1:0];
                        lat_size      <= DRAM_EX_TYPE;
                        lat_uns       <= Unsigned;
                        lat_rwsel     <= RWSel;
                        lat_regwr     <= RegWr;
                        lat_regwe     <= RegWe;
                        lat_pc        <= pc;
                        lat_alu       <= ALUOut;
                        RegWe_o       <= 1'b0;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    RegWe_o <= 1'b0;
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        load_data   <= ext_data;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    pc_o     <= lat_pc;
                    RegWr_o  <= lat_regwr;
                    RegWe_o  <= lat_regwe;
                    WBData_o <= (lat_rwsel == RWSEL_DRAM) ? load_data : lat_alu;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Vector table plus scoreboard bench for mem_access_unit with a wait-stated RAM responder.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [1:0]  dram_type;
    logic        dramwe;
    logic [1:0]  rwsel;
    logic [4:0]  regwr;
    logic        regwe;
    logic [31:0] aluout;
    logic [31:0] dramin;
    logic        uns;
    logic        stall;
    logic [31:0] pc_o;
    logic [4:0]  regwr_o;
    logic        regwe_o;
    logic [31:0] wbdata_o;
    logic        misalign_o;

    logic        resp_ack   = 1'b0;
    logic        stray_ack  = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic [31:0] cur_rdata  = '0;
    int          resp_waits = 0;
    int          wcnt       = 0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access_unit_if mif ();
    assign mif.bus_ack   = resp_ack | stray_ack;
    assign mif.bus_rdata = resp_rdata;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .DRAM_EX_TYPE (dram_type),
        .DRAMWE       (dramwe),
        .RWSel        (rwsel),
        .RegWr        (regwr),
        .RegWe        (regwe),
        .ALUOut       (aluout),
        .DRAMIn       (dramin),
        .Unsigned     (uns),
        .bus          (mif.master),
        .stall        (stall),
        .pc_o         (pc_o),
        .RegWr_o      (regwr_o),
        .RegWe_o      (regwe_o),
        .WBData_o     (wbdata_o),
        .misalign_o   (misalign_o)
    );

    // RAM model: acks after resp_waits idle cycles of a held request.
    always @(negedge clk) begin
        if (mif.bus_req) begin
            if (wcnt == resp_waits) begin
                resp_ack   = 1'b1;
                resp_rdata = cur_rdata;
                wcnt       = 0;
            end else begin
                resp_ack = 1'b0;
                wcnt     = wcnt + 1;
            end
        end else begin
            resp_ack = 1'b0;
            wcnt     = 0;
        end
    end

    typedef struct {
        logic [1:0]  typ;
        logic        we;
        logic [1:0]  rws;
        logic [4:0]  rd;
        logic        rwe;
        logic [31:0] alu;
        logic [31:0] din;
        logic        uns;
        logic [31:0] rdata;
        int          waits;
        int          exp_stall;
        int          exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        logic        exp_rwe;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rwe;
        logic [31:0] wb;
        logic        mis;
    } wb_t;

    wb_t  sb[$];
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Entered just after a rising edge; returns just after the edge that retires the instruction.
    task automatic run_vec(input vec_t v, input string tag, input logic [31:0] vpc);
        int          nst;
        int          nreq;
        logic        prev_req;
        logic        unstable;
        logic        done;
        logic        c_we;
        logic [31:0] c_addr;
        logic [3:0]  c_be;
        logic [31:0] c_wdata;
        wb_t         e;
        pc = vpc; dram_type = v.typ; dramwe = v.we; rwsel = v.rws; regwr = v.rd;
        regwe = v.rwe; aluout = v.alu; dramin = v.din; uns = v.uns;
        resp_waits = v.waits; cur_rdata = v.rdata;
        sb.push_back('{vpc, v.rd, v.exp_rwe, v.exp_wb, v.exp_mis});
        nst = 0; nreq = 0; prev_req = 1'b0; unstable = 1'b0; done = 1'b0;
        c_we = 1'b0; c_addr = '0; c_be = '0; c_wdata = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mif.bus_req && !prev_req) begin
                nreq++;
                c_we = mif.bus_we; c_addr = mif.bus_addr; c_be = mif.bus_be; c_wdata = mif.bus_wdata;
            end else if (mif.bus_req && (c_we !== mif.bus_we || c_addr !== mif.bus_addr ||
                                         c_be !== mif.bus_be || c_wdata !== mif.bus_wdata)) begin
                unstable = 1'b1;
            end
            prev_req = mif.bus_req;
            if (stall) nst++;
            else done = 1'b1;
        end
        chk({tag, " stall_release"}, {31'b0, done}, 32'd1);
        chk({tag, " stall_cycles"}, nst, v.exp_stall);
        chk({tag, " req_episodes"}, nreq, v.exp_req);
        if (v.exp_req != 0) begin
            chk({tag, " bus_we"}, {31'b0, c_we}, {31'b0, v.exp_we});
            chk({tag, " bus_addr"}, c_addr, v.exp_addr);
            chk({tag, " bus_be"}, {28'b0, c_be}, {28'b0, v.exp_be});
            chk({tag, " bus_wdata"}, c_wdata, v.exp_wdata);
            chk({tag, " bus_stable"}, {31'b0, unstable}, 32'd0);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " pc_o"}, pc_o, e.pc);
        chk({tag, " RegWr_o"}, {27'b0, regwr_o}, {27'b0, e.rd});
        chk({tag, " RegWe_o"}, {31'b0, regwe_o}, {31'b0, e.rwe});
        chk({tag, " misalign_o"}, {31'b0, misalign_o}, {31'b0, e.mis});
        if (!e.mis) chk({tag, " WBData_o"}, wbdata_o, e.wb);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " bus_req"}, {31'b0, mif.bus_req}, 32'd0);
        chk({tag, " stall"}, {31'b0, stall}, 32'd0);
        chk({tag, " pc_o"}, pc_o, 32'd0);
        chk({tag, " RegWe_o"}, {31'b0, regwe_o}, 32'd0);
        chk({tag, " WBData_o"}, wbdata_o, 32'd0);
        chk({tag, " misalign_o"}, {31'b0, misalign_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ok;
        vec_t post;
        //          typ    we rws   rd  rwe alu       din           uns rdata         w  st req we addr      be     wdata         wb            rwe mis
        vecs[0]  = '{2'b10, 1, 2'b00, 0,  0, 32'h100, 32'hDEADBEEF, 0, 32'h0,        2, 4, 1,  1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h100,      0,  0};
        vecs[1]  = '{2'b00, 0, 2'b01, 3,  1, 32'h203, 32'h0,        0, 32'h80FF0000, 0, 2, 1,  0, 32'h200, 4'h8, 32'h0,        32'hFFFFFF80, 1,  0};
        vecs[2]  = '{2'b00, 0, 2'b01, 3,  1, 32'h203, 32'h0,        1, 32'h80FF0000, 1, 3, 1,  0, 32'h200, 4'h8, 32'h0,        32'h00000080, 1,  0};
        vecs[3]  = '{2'b01, 1, 2'b00, 0,  0, 32'h12,  32'h0000ABCD, 0, 32'h0,        0, 2, 1,  1, 32'h10,  4'hC, 32'hABCDABCD, 32'h12,       0,  0};
        vecs[4]  = '{2'b01, 0, 2'b01, 4,  1, 32'h11,  32'h0,        0, 32'h0,        0, 0, 0,  0, 32'h0,   4'h0, 32'h0,        32'h11,       0,  1};
        vecs[5]  = '{2'b00, 0, 2'b00, 7,  1, 32'h55,  32'h0,        0, 32'h0,        0, 0, 0,  0, 32'h0,   4'h0, 32'h0,        32'h55,       1,  0};
        vecs[6]  = '{2'b10, 0, 2'b01, 9,  1, 32'h40,  32'h0,        0, 32'h12345678, 3, 5, 1,  0, 32'h40,  4'hF, 32'h0,        32'h12345678, 1,  0};
        vecs[7]  = '{2'b01, 0, 2'b01, 10, 1, 32'h22,  32'h0,        0, 32'h80017FFF, 0, 2, 1,  0, 32'h20,  4'hC, 32'h0,        32'hFFFF8001, 1,  0};
        vecs[8]  = '{2'b00, 1, 2'b00, 0,  0, 32'h31,  32'h000000A5, 0, 32'h0,        1, 3, 1,  1, 32'h30,  4'h2, 32'hA5A5A5A5, 32'h31,       0,  0};
        vecs[9]  = '{2'b10, 0, 2'b01, 11, 1, 32'h42,  32'h0,        0, 32'h0,        0, 0, 0,  0, 32'h0,   4'h0, 32'h0,        32'h42,       0,  1};
        vecs[10] = '{2'b11, 0, 2'b01, 12, 1, 32'h44,  32'h0,        0, 32'hCAFEF00D, 0, 2, 1,  0, 32'h44,  4'hF, 32'h0,        32'hCAFEF00D, 1,  0};
        vecs[11] = '{2'b01, 0, 2'b01, 13, 1, 32'h26,  32'h0,        1, 32'h9ABC1234, 0, 2, 1,  0, 32'h24,  4'hC, 32'h0,        32'h00009ABC, 1,  0};
        vecs[12] = '{2'b00, 0, 2'b01, 14, 1, 32'h61,  32'h0,        0, 32'h00007F00, 0, 2, 1,  0, 32'h60,  4'h2, 32'h0,        32'h0000007F, 1,  0};

        // Reset asserted with a live aligned access on the inputs: everything must still read 0.
        rst_n = 1'b0;
        pc = 32'h1000; dram_type = DRAM_WORD; dramwe = 1'b0; rwsel = RWSEL_DRAM;
        regwr = 5'd1; regwe = 1'b1; aluout = 32'h80; dramin = '0; uns = 1'b0;
        #12;
        check_zero_outputs("reset");
        rwsel = 2'b00; regwe = 1'b0;
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++)
            run_vec(vecs[i], $sformatf("v%0d", i), 32'h400 + 32'(i) * 4);

        // Reset in the middle of a long-waiting load.
        pc = 32'h500; dram_type = DRAM_WORD; dramwe = 1'b0; rwsel = RWSEL_DRAM;
        regwr = 5'd2; regwe = 1'b1; aluout = 32'h80; uns = 1'b0;
        resp_waits = 20; cur_rdata = 32'h11111111;
        ok = 1'b0;
        for (int c = 0; c < 5 && !ok; c++) begin
            @(negedge clk);
            ok = mif.bus_req;
        end
        chk("midreset req_seen", {31'b0, ok}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        rwsel = 2'b00; regwe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        post = '{2'b10, 0, 2'b01, 15, 1, 32'h84, 32'h0, 0, 32'h0BADF00D, 1, 3, 1, 0, 32'h84, 4'hF, 32'h0, 32'h0BADF00D, 1, 0};
        run_vec(post, "postreset", 32'h504);

        // Stray ack while idle on an ALU instruction.
        pc = 32'h600; dram_type = DRAM_BYTE; dramwe = 1'b0; rwsel = 2'b00;
        regwr = 5'd5; regwe = 1'b1; aluout = 32'h77; uns = 1'b0;
        cur_rdata = 32'hFFFFFFFF; stray_ack = 1'b1;
        @(negedge clk);
        chk("stray stall", {31'b0, stall}, 32'd0);
        chk("stray bus_req", {31'b0, mif.bus_req}, 32'd0);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        chk("stray WBData_o", wbdata_o, 32'h77);
        chk("stray RegWe_o", {31'b0, regwe_o}, 32'd1);
        chk("stray RegWr_o", {27'b0, regwr_o}, 32'd5);
        post = '{2'b00, 0, 2'b01, 16, 1, 32'h102, 32'h0, 1, 32'h00C30000, 0, 2, 1, 0, 32'h100, 4'h4, 32'h0, 32'h000000C3, 1, 0};
        run_vec(post, "afterstray", 32'h604);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
